// File: rtl/rename_pkg.sv
// Shared types and constants for the rename stage.
// Contents: register-file sizing, physical-register index type, decoded
// opcode encodings and the "instruction writes a destination" predicate.
package rename_pkg;

  localparam int NUM_AREGS = 32;
  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int FL_CNT_W  = FL_PTR_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;

  typedef enum logic [6:0] {
    OP_RTYPE = 7'b0110011,
    OP_ITYPE = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011
  } opcode_e;

  // Stores, empty slots (opcode 0) and writes to x0 allocate nothing.
  function automatic logic writes_rd(input logic [6:0] op, input areg_t rd);
    return (op != OP_STORE) && (op != 7'd0) && (rd != '0);
  endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// free_list: circular FIFO of free physical registers.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pop_cnt                  entries consumed this cycle (0..2), taken from head
//   push_en_1/2, push_preg_1/2  returned registers; p0 is ignored, slot 1 first
//   head_preg, next_preg     entries at head and head+1
//   count                    current occupancy (0..FL_DEPTH)
module free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pop_cnt,
  input  logic                push_en_1,
  input  preg_t               push_preg_1,
  input  logic                push_en_2,
  input  preg_t               push_preg_2,
  output preg_t               head_preg,
  output preg_t               next_preg,
  output logic [FL_CNT_W-1:0] count
);

  preg_t                mem [FL_DEPTH];
  logic [FL_PTR_W-1:0]  head;
  logic [FL_PTR_W-1:0]  tail;
  logic                 v1, v2;
  logic                 acc1, acc2;
  logic [FL_CNT_W-1:0]  req_total;

  assign head_preg = mem[head];
  assign next_preg = mem[head + FL_PTR_W'(1)];

  assign v1 = push_en_1 && (push_preg_1 != '0);
  assign v2 = push_en_2 && (push_preg_2 != '0);

  // Overflowing pushes are dropped; occupancy checked before this cycle's pops.
  assign acc1 = v1 && (count < FL_CNT_W'(FL_DEPTH));
  assign acc2 = v2 && ((count + FL_CNT_W'(acc1)) < FL_CNT_W'(FL_DEPTH));

  assign req_total = count + FL_CNT_W'(v1) + FL_CNT_W'(v2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++)
        mem[i] <= preg_t'(NUM_AREGS + i);
      head  <= '0;
      tail  <= '0;
      count <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (acc1) mem[tail] <= push_preg_1;
      if (acc2) mem[tail + FL_PTR_W'(acc1)] <= push_preg_2;
      head  <= head + FL_PTR_W'(pop_cnt);
      tail  <= tail + FL_PTR_W'(acc1) + FL_PTR_W'(acc2);
      count <= count + FL_CNT_W'(acc1) + FL_CNT_W'(acc2) - FL_CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (req_total <= FL_CNT_W'(FL_DEPTH));
  end

endmodule

// File: rtl/rename_stage.sv
// rename_stage: dual-issue register rename between decode and dispatch.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   en_flag_i                      decoded pair valid
//   opcode_n, rs1_n, rs2_n, rd_n   decoded fields, slot n (1/2)
//   instr_1_, instr_2_             raw instructions, passed through
//   retire_en_n, retire_preg_n     commit returns a physical register
//   stall_o                        combinational hold request to decode
//   en_flag_o                      renamed pair valid (registered)
//   prs1_n, prs2_n, prd_n, old_prd_n  renamed sources / new dest / old dest
//   instr_1_o, instr_2_o           registered raw instructions
module rename_stage
  import rename_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_flag_i,
  input  logic [6:0]  opcode_1,
  input  logic [6:0]  opcode_2,
  input  logic [4:0]  rs1_1,
  input  logic [4:0]  rs1_2,
  input  logic [4:0]  rs2_1,
  input  logic [4:0]  rs2_2,
  input  logic [4:0]  rd_1,
  input  logic [4:0]  rd_2,
  input  logic [31:0] instr_1_,
  input  logic [31:0] instr_2_,
  input  logic        retire_en_1,
  input  logic        retire_en_2,
  input  preg_t       retire_preg_1,
  input  preg_t       retire_preg_2,
  output logic        stall_o,
  output logic        en_flag_o,
  output preg_t       prs1_1,
  output preg_t       prs1_2,
  output preg_t       prs2_1,
  output preg_t       prs2_2,
  output preg_t       prd_1,
  output preg_t       prd_2,
  output preg_t       old_prd_1,
  output preg_t       old_prd_2,
  output logic [31:0] instr_1_o,
  output logic [31:0] instr_2_o
);

  preg_t               rat [NUM_AREGS];
  logic                writes_1, writes_2, accept;
  logic [1:0]          need, pop_cnt;
  logic [FL_CNT_W-1:0] fl_count;
  preg_t               head_preg, next_preg;
  preg_t               alloc_1, alloc_2;
  preg_t               s11, s21, s12, s22, old_1, old_2;

  free_list u_free_list (
    .clk         (clk),
    .rst         (rst),
    .pop_cnt     (pop_cnt),
    .push_en_1   (retire_en_1),
    .push_preg_1 (retire_preg_1),
    .push_en_2   (retire_en_2),
    .push_preg_2 (retire_preg_2),
    .head_preg   (head_preg),
    .next_preg   (next_preg),
    .count       (fl_count)
  );

  assign writes_1 = writes_rd(opcode_1, rd_1);
  assign writes_2 = writes_rd(opcode_2, rd_2);
  assign need     = 2'(writes_1) + 2'(writes_2);
  assign stall_o  = en_flag_i && (fl_count < FL_CNT_W'(need));
  assign accept   = en_flag_i && !stall_o;
  assign pop_cnt  = accept ? need : 2'd0;

  always_comb begin
    alloc_1 = writes_1 ? head_preg : '0;
    alloc_2 = '0;
    if (writes_2) alloc_2 = writes_1 ? next_preg : head_preg;

    s11 = (rs1_1 == '0) ? '0 : rat[rs1_1];
    s21 = (rs2_1 == '0) ? '0 : rat[rs2_1];
    s12 = (rs1_2 == '0) ? '0 : rat[rs1_2];
    s22 = (rs2_2 == '0) ? '0 : rat[rs2_2];
    // Slot 2 sees slot 1's new destination; writes_1 already excludes rd_1 == x0.
    if (writes_1 && rs1_2 == rd_1) s12 = alloc_1;
    if (writes_1 && rs2_2 == rd_1) s22 = alloc_1;

    old_1 = writes_1 ? rat[rd_1] : '0;
    old_2 = '0;
    if (writes_2) old_2 = (writes_1 && rd_2 == rd_1) ? alloc_1 : rat[rd_2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++)
        rat[i] <= preg_t'(i);
      en_flag_o <= 1'b0;
      prs1_1    <= '0;
      prs1_2    <= '0;
      prs2_1    <= '0;
      prs2_2    <= '0;
      prd_1     <= '0;
      prd_2     <= '0;
      old_prd_1 <= '0;
      old_prd_2 <= '0;
      instr_1_o <= '0;
      instr_2_o <= '0;
    end else begin
      en_flag_o <= accept;
      if (accept) begin
        // Slot 2 assigned last so it wins when both slots name the same rd.
        if (writes_1) rat[rd_1] <= alloc_1;
        if (writes_2) rat[rd_2] <= alloc_2;
        prs1_1    <= s11;
        prs2_1    <= s21;
        prs1_2    <= s12;
        prs2_2    <= s22;
        prd_1     <= alloc_1;
        prd_2     <= alloc_2;
        old_prd_1 <= old_1;
        old_prd_2 <= old_2;
        instr_1_o <= instr_1_;
        instr_2_o <= instr_2_;
      end
    end
  end

endmodule
